// File: rtl/vga_pkg.sv
// Shared types and colour constants for the VGA timing generator and its pattern source.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRID   = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_STREAM = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_BLACK   = 24'h000000;

  // Index 0 is the leftmost bar.
  localparam rgb_t [7:0] BAR_TABLE = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                      RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel stream handshake between the line FIFO (master) and the timing generator (slave).
interface vga_timing_gen_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_pattern.sv
// Combinational image source: picks the colour of pixel (px, py) for the frame's latched mode.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          GRID_LOG2 = 4,
  parameter int          PXW       = 10,
  parameter int          PYW       = 10,
  parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
  input  logic [PXW-1:0] px,
  input  logic [PYW-1:0] py,
  input  mode_e          mode_q,
  input  rgb_t           pix_data,
  output rgb_t           rgb
);

  localparam int BAR_W = HDISP / 8;

  logic [2:0] bar_idx;
  logic       unused_py_bits;

  assign unused_py_bits = ^py;

  // Bar index is the number of constant bar boundaries already passed.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar_idx = bar_idx + {2'b00, (int'(px) >= k * BAR_W)};
    end
  end

  // Colour selection per mode.
  always_comb begin
    rgb = RGB_BLACK;
    case (mode_q)
      MODE_GRID: begin
        if ((px[GRID_LOG2-1:0] == '0) || (py[GRID_LOG2-1:0] == '0)) begin
          rgb = RGB_WHITE;
        end else begin
          rgb = RGB_BLACK;
        end
      end
      MODE_BARS:   rgb = BAR_TABLE[bar_idx];
      MODE_STREAM: rgb = pix_data;
      MODE_SOLID:  rgb = rgb_t'(SOLID_RGB);
      default:     rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync, stream handshake and registered video outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          HFP       = 40,
  parameter int          HPULSE    = 48,
  parameter int          HBP       = 40,
  parameter int          VFP       = 13,
  parameter int          VPULSE    = 3,
  parameter int          VBP       = 29,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int          GRID_LOG2 = 4,
  parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic [1:0]       mode,
  input  logic             underflow_clr,
  vga_timing_gen_if.slave  pix_if,
  output logic             hs,
  output logic             vs,
  output logic             blank,
  output logic [23:0]      rgb,
  output logic             frame_start,
  output logic             underflow
);

  localparam int XLEN = HDISP + HFP + HPULSE + HBP;
  localparam int YLEN = VDISP + VFP + VPULSE + VBP;
  localparam int PXW  = $clog2(XLEN);
  localparam int PYW  = $clog2(YLEN);

  localparam logic [PXW-1:0] X_ONE    = PXW'(1);
  localparam logic [PXW-1:0] X_LAST   = PXW'(XLEN - 1);
  localparam logic [PXW-1:0] X_DISP   = PXW'(HDISP);
  localparam logic [PXW-1:0] X_HS_ON  = PXW'(HDISP + HFP);
  localparam logic [PXW-1:0] X_HS_OFF = PXW'(HDISP + HFP + HPULSE);
  localparam logic [PYW-1:0] Y_ONE    = PYW'(1);
  localparam logic [PYW-1:0] Y_LAST   = PYW'(YLEN - 1);
  localparam logic [PYW-1:0] Y_DISP   = PYW'(VDISP);
  localparam logic [PYW-1:0] Y_VS_ON  = PYW'(VDISP + VFP);
  localparam logic [PYW-1:0] Y_VS_OFF = PYW'(VDISP + VFP + VPULSE);

  if ((HDISP % 8) != 0) begin : g_bad_hdisp
    $fatal(1, "vga_timing_gen: HDISP must be divisible by 8");
  end
  if ((HDISP < 1) || (VDISP < 1) || (HFP < 1) || (HPULSE < 1) || (HBP < 1) ||
      (VFP < 1) || (VPULSE < 1) || (VBP < 1) || (GRID_LOG2 < 1)) begin : g_bad_param
    $fatal(1, "vga_timing_gen: timing parameters must be >= 1");
  end

  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  mode_e          mode_q, mode_d;
  logic           hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic           frame_start_q, frame_start_d, underflow_q, underflow_d;
  rgb_t           rgb_q, rgb_d, pattern_rgb;
  logic           line_end, frame_end, active, pix_ready, pix_miss;

  vga_pattern #(
    .HDISP(HDISP), .GRID_LOG2(GRID_LOG2), .PXW(PXW), .PYW(PYW), .SOLID_RGB(SOLID_RGB)
  ) u_pattern (
    .px(px_q), .py(py_q), .mode_q(mode_q), .pix_data(rgb_t'(pix_if.pix_data)), .rgb(pattern_rgb)
  );

  // Ready depends only on counters and latched mode, so it is low while in reset.
  assign active           = (px_q < X_DISP) && (py_q < Y_DISP);
  assign pix_ready        = active && (mode_q == MODE_STREAM);
  assign pix_miss         = pix_ready && !pix_if.pix_valid;
  assign pix_if.pix_ready = pix_ready;

  // Next-state for counters, mode latch and every registered output.
  always_comb begin
    line_end      = (px_q == X_LAST);
    frame_end     = line_end && (py_q == Y_LAST);
    px_d          = line_end ? '0 : (px_q + X_ONE);
    py_d          = py_q;
    mode_d        = mode_q;
    hs_d          = ((px_q >= X_HS_ON) && (px_q < X_HS_OFF)) ? HS_POL : ~HS_POL;
    vs_d          = ((py_q >= Y_VS_ON) && (py_q < Y_VS_OFF)) ? VS_POL : ~VS_POL;
    blank_d       = active;
    frame_start_d = (px_q == '0) && (py_q == '0);
    rgb_d         = RGB_BLACK;
    underflow_d   = underflow_q;
    if (line_end) begin
      py_d = frame_end ? '0 : (py_q + Y_ONE);
    end else begin
      py_d = py_q;
    end
    if (frame_end) begin
      mode_d = mode_e'(mode);
    end else begin
      mode_d = mode_q;
    end
    // A missing stream pixel is dropped as black; timing never stalls.
    if (!active || pix_miss) begin
      rgb_d = RGB_BLACK;
    end else begin
      rgb_d = pattern_rgb;
    end
    if (pix_miss) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State and output registers.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      px_q          <= '0;
      py_q          <= '0;
      mode_q        <= MODE_GRID;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_q       <= 1'b0;
      rgb_q         <= RGB_BLACK;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      px_q          <= px_d;
      py_q          <= py_d;
      mode_q        <= mode_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 23x12 toy raster with a reference model and scoreboard.
module tb_vga_timing_gen;

  localparam int XL = 23;
  localparam int YL = 12;
  localparam int FR = XL * YL;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_in;
  logic        clr_in;
  logic        hs, vs, blank, fs, und;
  logic [23:0] rgb;

  vga_timing_gen_if pif ();

  vga_timing_gen #(
    .HDISP(16), .VDISP(8), .HFP(2), .HPULSE(3), .HBP(2),
    .VFP(1), .VPULSE(2), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .GRID_LOG2(2), .SOLID_RGB(24'h0000FF)
  ) dut (
    .pixel_clk(clk), .pixel_rst(rst), .mode(mode_in), .underflow_clr(clr_in),
    .pix_if(pif), .hs(hs), .vs(vs), .blank(blank), .rgb(rgb),
    .frame_start(fs), .underflow(und)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic        und;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    int          tag;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vt[$];
  int          n_cmp = 0, n_fail = 0;
  int          mx, my, cyc, last_fs;
  logic [1:0]  mm;
  logic        mu;
  logic [23:0] cap [XL][YL];
  logic [23:0] dat [XL][YL];
  int          n_blank, n_vs_low, n_hs_low, n_fs, n_xfer;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s cyc=%0d pos=(%0d,%0d): got %0h want %0h", nm, cyc, mx, my, act, exp);
    end
  endtask

  function automatic logic [23:0] bar_col(input int i);
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // One pixel clock: predict, push, clock, pop and compare, then advance the model.
  task automatic step();
    exp_t e;
    logic act_m, rdy;
    act_m = (mx < 16) && (my < 8);
    rdy   = act_m && (mm == 2'd2);
    chk("pix_ready", {31'd0, pif.pix_ready}, {31'd0, rdy});
    e.hs    = !((mx >= 18) && (mx < 21));
    e.vs    = !((my >= 9) && (my < 11));
    e.blank = act_m;
    e.fs    = (mx == 0) && (my == 0);
    if (!act_m) e.rgb = 24'h0;
    else case (mm)
      2'd0:    e.rgb = ((mx % 4 == 0) || (my % 4 == 0)) ? 24'hFFFFFF : 24'h0;
      2'd1:    e.rgb = bar_col(mx * 8 / 16);
      2'd2:    e.rgb = pif.pix_valid ? pif.pix_data : 24'h0;
      default: e.rgb = 24'h0000FF;
    endcase
    e.und = (rdy && !pif.pix_valid) ? 1'b1 : (clr_in ? 1'b0 : mu);
    sb_q.push_back(e);
    dat[mx][my] = pif.pix_data;
    if (rdy && pif.pix_valid) n_xfer++;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("hs", {31'd0, hs}, {31'd0, e.hs});
    chk("vs", {31'd0, vs}, {31'd0, e.vs});
    chk("blank", {31'd0, blank}, {31'd0, e.blank});
    chk("frame_start", {31'd0, fs}, {31'd0, e.fs});
    chk("underflow", {31'd0, und}, {31'd0, e.und});
    chk("rgb", {8'd0, rgb}, {8'd0, e.rgb});
    n_blank  += int'(blank);
    n_vs_low += int'(!vs);
    n_hs_low += int'(!hs);
    if (fs) begin
      n_fs++;
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, FR);
      last_fs = cyc;
    end
    cap[mx][my] = rgb;
    mu = e.und;
    if (rdy && pif.pix_valid) pif.pix_data = pif.pix_data + 24'd1;
    if ((mx == XL - 1) && (my == YL - 1)) mm = mode_in;
    if (mx == XL - 1) begin
      mx = 0;
      my = (my == YL - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    cyc++;
  endtask

  task automatic run_frame(input int n, input int miss_x, input int miss_y,
                           input int clr_x, input int clr_y,
                           input int chg_x, input int chg_y, input logic [1:0] chg_md);
    n_blank = 0; n_vs_low = 0; n_hs_low = 0; n_fs = 0; n_xfer = 0;
    for (int i = 0; i < n; i++) begin
      pif.pix_valid = !((mx == miss_x) && (my == miss_y));
      clr_in        = (mx == clr_x) && (my == clr_y);
      if ((mx == chg_x) && (my == chg_y)) mode_in = chg_md;
      step();
    end
    pif.pix_valid = 1'b1;
    clr_in        = 1'b0;
    if (n == FR) begin
      chk("blank_per_frame", n_blank, 128);
      chk("vs_low_per_frame", n_vs_low, 46);
      chk("hs_low_per_frame", n_hs_low, 36);
      chk("fs_per_frame", n_fs, 1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_hs", {31'd0, hs}, 32'd1);
    chk("rst_vs", {31'd0, vs}, 32'd1);
    chk("rst_blank", {31'd0, blank}, 32'd0);
    chk("rst_rgb", {8'd0, rgb}, 32'd0);
    chk("rst_fs", {31'd0, fs}, 32'd0);
    chk("rst_underflow", {31'd0, und}, 32'd0);
    chk("rst_pix_ready", {31'd0, pif.pix_ready}, 32'd0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    mx = 0; my = 0; mm = 2'd0; mu = 1'b0; last_fs = -1;
    sb_q.delete();
  endtask

  task automatic check_table(input int tag);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].tag == tag) chk($sformatf("pattern_t%0d_(%0d,%0d)", tag, vt[i].x, vt[i].y),
                                {8'd0, cap[vt[i].x][vt[i].y]}, {8'd0, vt[i].rgb});
    end
  endtask

  initial begin
    vt = '{
      '{0, 0, 1, 24'hFFFFFF}, '{0, 0, 5, 24'hFFFFFF}, '{0, 4, 2, 24'hFFFFFF},
      '{0, 4, 7, 24'hFFFFFF}, '{0, 3, 4, 24'hFFFFFF}, '{0, 9, 4, 24'hFFFFFF},
      '{0, 1, 1, 24'h000000}, '{0, 5, 6, 24'h000000}, '{0, 16, 2, 24'h000000},
      '{0, 2, 9, 24'h000000},
      '{1, 0, 2, 24'hFFFFFF}, '{1, 1, 5, 24'hFFFFFF}, '{1, 2, 0, 24'hFFFF00},
      '{1, 3, 7, 24'hFFFF00}, '{1, 4, 3, 24'h00FFFF}, '{1, 10, 4, 24'hFF0000},
      '{1, 14, 1, 24'h000000}, '{1, 15, 6, 24'h000000}, '{1, 18, 2, 24'h000000}
    };
    rst = 1'b1; mode_in = 2'd0; clr_in = 1'b0;
    pif.pix_valid = 1'b1; pif.pix_data = 24'h000001;
    mx = 0; my = 0; mm = 2'd0; mu = 1'b0; cyc = 0; last_fs = -1;
    @(posedge clk); #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    release_reset();

    run_frame(FR, -1, -1, -1, -1, -1, -1, 2'd0);
    check_table(0);
    // Bars requested mid-frame: this frame must remain grid.
    run_frame(FR, -1, -1, -1, -1, 5, 3, 2'd1);
    check_table(0);
    run_frame(FR, -1, -1, -1, -1, 1, 0, 2'd2);
    check_table(1);

    run_frame(FR, -1, -1, -1, -1, -1, -1, 2'd2);
    chk("stream_xfers", n_xfer, 128);
    chk("stream_first_word", {8'd0, cap[0][0]}, {8'd0, dat[0][0]});

    run_frame(FR, 5, 3, -1, -1, -1, -1, 2'd2);
    chk("miss_pixel_black", {8'd0, cap[5][3]}, 32'd0);
    chk("miss_left_neighbour", {8'd0, cap[4][3]}, {8'd0, dat[4][3]});
    chk("miss_right_neighbour", {8'd0, cap[6][3]}, {8'd0, dat[4][3] + 24'd1});
    chk("miss_xfers", n_xfer, 127);
    chk("underflow_sticky", {31'd0, und}, 32'd1);

    run_frame(FR, 2, 1, 2, 1, -1, -1, 2'd2);
    chk("underflow_set_beats_clr", {31'd0, und}, 32'd1);
    run_frame(FR, -1, -1, 3, 9, -1, -1, 2'd2);
    chk("underflow_cleared", {31'd0, und}, 32'd0);

    run_frame(10 + 6 * XL, 0, 0, -1, -1, -1, -1, 2'd2);
    chk("pre_reset_underflow", {31'd0, und}, 32'd1);
    chk("pre_reset_ready", {31'd0, pif.pix_ready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    release_reset();
    run_frame(FR, -1, -1, -1, -1, -1, -1, 2'd2);
    check_table(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
